// File: rtl/ldst_seq.sv
// Load/store descriptor sequencer between the TPU core issue stage and one DMem port.
// Latches a strided descriptor, requests DMem, then counts data beats to completion.
module ldst_seq #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_Cmd_Valid,
    input  logic              I_Cmd_Store,
    input  logic [ADDR_W-1:0] I_Cmd_Base,
    input  logic [ADDR_W-1:0] I_Cmd_Stride,
    input  logic [LEN_W-1:0]  I_Cmd_Len,
    output logic              O_Cmd_Ready,
    output logic              O_Req,
    output logic              O_V,
    output logic              O_Is_St,
    output logic [ADDR_W-1:0] O_Base,
    output logic [ADDR_W-1:0] O_Stride,
    output logic [LEN_W-1:0]  O_Len,
    input  logic              I_Grant,
    input  logic              I_Ready,
    input  logic              I_Core_St_V,
    input  logic [DATA_W-1:0] I_Core_St_Data,
    output logic              O_Core_St_Stall,
    output logic              O_St_V,
    output logic [DATA_W-1:0] O_St_Data,
    input  logic              I_Ld_V,
    input  logic [DATA_W-1:0] I_Ld_Data,
    output logic              O_Core_Ld_V,
    output logic [DATA_W-1:0] O_Core_Ld_Data,
    output logic              O_Busy,
    output logic              O_Done,
    output logic              O_Err
);

    // state | meaning
    // IDLE  | ready for a command
    // REQ   | descriptor presented, waiting for grant and ready together
    // XFER  | counting data beats
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  cnt;
    logic [ADDR_W-1:0] base_q, stride_q;
    logic [LEN_W-1:0]  len_q;
    logic              is_st_q;
    logic              err_q;
    logic              zero_done_q;
    logic              st_v_q, ld_v_q;
    logic [DATA_W-1:0] st_data_q, ld_data_q;
    logic              accept, st_beat, ld_beat, err_set;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        O_Cmd_Ready     = 1'b0;
        O_Req           = 1'b0;
        O_V             = 1'b0;
        O_Busy          = 1'b1;
        O_Core_St_Stall = 1'b1;
        accept          = 1'b0;
        st_beat         = 1'b0;
        ld_beat         = 1'b0;
        case (state)
            IDLE: begin
                O_Cmd_Ready     = 1'b1;
                O_Busy          = 1'b0;
                O_Core_St_Stall = 1'b0;
                accept          = I_Cmd_Valid;
                if (I_Cmd_Valid && (I_Cmd_Len != '0)) state_nxt = REQ;
            end
            REQ: begin
                O_Req = 1'b1;
                O_V   = 1'b1;
                if (I_Grant && I_Ready) state_nxt = XFER;
            end
            XFER: begin
                // During a load the core store path stays stalled.
                if (is_st_q) begin
                    O_Core_St_Stall = ~I_Ready;
                    st_beat         = I_Core_St_V & I_Ready;
                end else begin
                    ld_beat = I_Ld_V;
                end
                if ((st_beat || ld_beat) && (cnt == LEN_W'(1))) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load data outside a load transfer, or core store data during a load, is a protocol error.
    assign err_set = (I_Ld_V & ~((state == XFER) & ~is_st_q))
                   | ((state == XFER) & ~is_st_q & I_Core_St_V);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            base_q      <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            is_st_q     <= 1'b0;
            err_q       <= 1'b0;
            zero_done_q <= 1'b0;
            st_v_q      <= 1'b0;
            ld_v_q      <= 1'b0;
            st_data_q   <= '0;
            ld_data_q   <= '0;
        end else begin
            st_v_q      <= st_beat;
            ld_v_q      <= ld_beat;
            zero_done_q <= accept && (I_Cmd_Len == '0);
            if (st_beat) st_data_q <= I_Core_St_Data;
            if (ld_beat) ld_data_q <= I_Ld_Data;
            if (accept && (I_Cmd_Len != '0)) begin
                base_q   <= I_Cmd_Base;
                stride_q <= I_Cmd_Stride;
                len_q    <= I_Cmd_Len;
                is_st_q  <= I_Cmd_Store;
                cnt      <= I_Cmd_Len;
            end else if (st_beat || ld_beat) begin
                cnt <= cnt - LEN_W'(1);
            end
            if (err_set)     err_q <= 1'b1;
            else if (accept) err_q <= 1'b0;
        end
    end

    assign O_Is_St        = is_st_q;
    assign O_Base         = base_q;
    assign O_Stride       = stride_q;
    assign O_Len          = len_q;
    assign O_St_V         = st_v_q;
    assign O_St_Data      = st_data_q;
    assign O_Core_Ld_V    = ld_v_q;
    assign O_Core_Ld_Data = ld_data_q;
    assign O_Done         = (state == DONE) | zero_done_q;
    assign O_Err          = err_q;

endmodule

// File: tb/tb_ldst_seq.sv
// Bench for ldst_seq: constant vector table, directed multi-cycle sequences and
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_ldst_seq;
    localparam int AW = 12;
    localparam int LW = 12;
    localparam int DW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, I_Cmd_Valid, I_Cmd_Store, I_Grant, I_Ready, I_Core_St_V, I_Ld_V;
    logic [AW-1:0] I_Cmd_Base, I_Cmd_Stride;
    logic [LW-1:0] I_Cmd_Len;
    logic [DW-1:0] I_Core_St_Data, I_Ld_Data;
    logic          O_Cmd_Ready, O_Req, O_V, O_Is_St, O_Core_St_Stall, O_St_V, O_Core_Ld_V;
    logic          O_Busy, O_Done, O_Err;
    logic [AW-1:0] O_Base, O_Stride;
    logic [LW-1:0] O_Len;
    logic [DW-1:0] O_St_Data, O_Core_Ld_Data;

    ldst_seq #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .I_Cmd_Valid(I_Cmd_Valid), .I_Cmd_Store(I_Cmd_Store), .I_Cmd_Base(I_Cmd_Base),
        .I_Cmd_Stride(I_Cmd_Stride), .I_Cmd_Len(I_Cmd_Len), .O_Cmd_Ready(O_Cmd_Ready),
        .O_Req(O_Req), .O_V(O_V), .O_Is_St(O_Is_St), .O_Base(O_Base), .O_Stride(O_Stride),
        .O_Len(O_Len), .I_Grant(I_Grant), .I_Ready(I_Ready), .I_Core_St_V(I_Core_St_V),
        .I_Core_St_Data(I_Core_St_Data), .O_Core_St_Stall(O_Core_St_Stall), .O_St_V(O_St_V),
        .O_St_Data(O_St_Data), .I_Ld_V(I_Ld_V), .I_Ld_Data(I_Ld_Data),
        .O_Core_Ld_V(O_Core_Ld_V), .O_Core_Ld_Data(O_Core_Ld_Data), .O_Busy(O_Busy),
        .O_Done(O_Done), .O_Err(O_Err)
    );

    typedef struct {
        logic          rst, valid, store;
        logic [AW-1:0] base, stride;
        logic [LW-1:0] len;
        logic          grant, ready, cst_v;
        logic [DW-1:0] cst_data;
        logic          ld_v;
        logic [DW-1:0] ld_data;
    } in_t;

    typedef struct {
        logic          valid, store;
        logic [LW-1:0] len;
        logic          ld_v;
        logic          e_req, e_done, e_busy, e_err;
    } row_t;

    int checks = 0;
    int errors = 0;
    int st_pulses, ld_pulses, done_pulses, req_pulses;
    logic [DW-1:0] st_log[$];
    logic [DW-1:0] ld_log[$];

    // Model: phase 0 idle, 1 requesting, 2 transferring, 3 completing.
    int            ph;
    int            m_rem;
    logic          m_st, m_err, m_zdone, m_stv, m_ldv;
    logic [AW-1:0] m_base, m_stride;
    logic [LW-1:0] m_len;
    logic [DW-1:0] m_std, m_ldd;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; m_rem = 0; m_st = 0; m_err = 0; m_zdone = 0; m_stv = 0; m_ldv = 0;
        m_base = '0; m_stride = '0; m_len = '0; m_std = '0; m_ldd = '0;
    endtask

    task automatic model_step(input in_t x);
        logic acc, xf, sb, lb, es;
        acc = (ph == 0) && x.valid;
        xf  = (ph == 2);
        sb  = xf && m_st && x.cst_v && x.ready;
        lb  = xf && !m_st && x.ld_v;
        es  = (x.ld_v && !(xf && !m_st)) || (xf && !m_st && x.cst_v);
        m_stv = sb;
        if (sb) m_std = x.cst_data;
        m_ldv = lb;
        if (lb) m_ldd = x.ld_data;
        m_zdone = acc && (x.len == 0);
        if (es) m_err = 1'b1;
        else if (acc) m_err = 1'b0;
        case (ph)
            0: if (acc && x.len != 0) begin
                m_base = x.base; m_stride = x.stride; m_len = x.len; m_st = x.store;
                m_rem = int'(x.len); ph = 1;
            end
            1: if (x.grant && x.ready) ph = 2;
            2: if (sb || lb) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) ph = 3;
            end
            default: ph = 0;
        endcase
    endtask

    task automatic tick(input in_t x);
        @(negedge clock);
        reset = x.rst; I_Cmd_Valid = x.valid; I_Cmd_Store = x.store; I_Cmd_Base = x.base;
        I_Cmd_Stride = x.stride; I_Cmd_Len = x.len; I_Grant = x.grant; I_Ready = x.ready;
        I_Core_St_V = x.cst_v; I_Core_St_Data = x.cst_data; I_Ld_V = x.ld_v; I_Ld_Data = x.ld_data;
        #1;
        if (!x.rst) model_reset();
        chk("cmd_ready", O_Cmd_Ready, ph == 0);
        chk("busy", O_Busy, ph != 0);
        chk("req", O_Req, ph == 1);
        chk("v", O_V, ph == 1);
        chk("done", O_Done, (ph == 3) || m_zdone);
        chk("err", O_Err, m_err);
        chk("is_st", O_Is_St, m_st);
        chk("base", O_Base, m_base);
        chk("stride", O_Stride, m_stride);
        chk("len", O_Len, m_len);
        if (ph != 2 || m_st) chk("stall", O_Core_St_Stall, (ph == 0) ? 1'b0 : (ph == 2) ? !x.ready : 1'b1);
        chk("st_v", O_St_V, m_stv);
        if (m_stv) chk("st_data", O_St_Data, m_std);
        chk("ld_v", O_Core_Ld_V, m_ldv);
        if (m_ldv) chk("ld_data", O_Core_Ld_Data, m_ldd);
        if (O_St_V) begin st_pulses++; st_log.push_back(O_St_Data); end
        if (O_Core_Ld_V) begin ld_pulses++; ld_log.push_back(O_Core_Ld_Data); end
        if (O_Done) done_pulses++;
        if (O_Req) req_pulses++;
        if (x.rst) model_step(x);
    endtask

    function automatic in_t idle_in();
        in_t x;
        x.rst = 1'b1; x.valid = 1'b0; x.store = 1'b0; x.base = '0; x.stride = '0; x.len = '0;
        x.grant = 1'b0; x.ready = 1'b0; x.cst_v = 1'b0; x.cst_data = '0; x.ld_v = 1'b0;
        x.ld_data = '0;
        return x;
    endfunction

    function automatic in_t cmd_in(input logic store, input int len);
        in_t x = idle_in();
        x.valid = 1'b1; x.store = store; x.len = LW'(len);
        x.base = AW'(12'h100 + len); x.stride = AW'(4);
        return x;
    endfunction

    task automatic clear_counts();
        st_pulses = 0; ld_pulses = 0; done_pulses = 0; req_pulses = 0;
        st_log.delete(); ld_log.delete();
    endtask

    task automatic do_reset();
        in_t x = idle_in();
        x.rst = 1'b0;
        tick(x);
        tick(idle_in());
        clear_counts();
    endtask

    row_t tbl[5];
    in_t  x;

    initial begin
        reset = 1'b0; I_Cmd_Valid = 0; I_Cmd_Store = 0; I_Cmd_Base = '0; I_Cmd_Stride = '0;
        I_Cmd_Len = '0; I_Grant = 0; I_Ready = 0; I_Core_St_V = 0; I_Core_St_Data = '0;
        I_Ld_V = 0; I_Ld_Data = '0;
        model_reset();
        clear_counts();

        tbl[0] = '{valid:0, store:0, len:0,  ld_v:0, e_req:0, e_done:0, e_busy:0, e_err:0};
        tbl[1] = '{valid:1, store:0, len:0,  ld_v:0, e_req:0, e_done:1, e_busy:0, e_err:0};
        tbl[2] = '{valid:0, store:0, len:0,  ld_v:1, e_req:0, e_done:0, e_busy:0, e_err:1};
        tbl[3] = '{valid:1, store:1, len:5,  ld_v:0, e_req:1, e_done:0, e_busy:1, e_err:0};
        tbl[4] = '{valid:1, store:0, len:12'hFFF, ld_v:0, e_req:1, e_done:0, e_busy:1, e_err:0};

        // Reset state
        x = idle_in(); x.rst = 1'b0;
        tick(x);
        chk("rst_cmd_ready", O_Cmd_Ready, 1'b1);
        chk("rst_busy", O_Busy, 1'b0);
        chk("rst_stall", O_Core_St_Stall, 1'b0);
        chk("rst_base", O_Base, '0);

        // Table vectors: one cycle from a fresh IDLE, then explicit expectations.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            x = idle_in();
            x.valid = tbl[i].valid; x.store = tbl[i].store; x.len = tbl[i].len; x.ld_v = tbl[i].ld_v;
            tick(x);
            tick(idle_in());
            chk($sformatf("tbl%0d_req", i), O_Req, tbl[i].e_req);
            chk($sformatf("tbl%0d_done", i), O_Done, tbl[i].e_done);
            chk($sformatf("tbl%0d_busy", i), O_Busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_err", i), O_Err, tbl[i].e_err);
        end

        // Store len=3, immediate grant, data A,B,C
        do_reset();
        tick(cmd_in(1'b1, 3));
        x = idle_in(); x.grant = 1; x.ready = 1; tick(x);
        for (int i = 0; i < 3; i++) begin
            x = idle_in(); x.ready = 1; x.cst_v = 1; x.cst_data = 32'hA0A0_0000 + i; tick(x);
        end
        for (int i = 0; i < 3; i++) tick(idle_in());
        chk("st3_count", st_pulses, 3);
        if (st_log.size() == 3) begin
            chk("st3_a", st_log[0], 32'hA0A0_0000);
            chk("st3_c", st_log[2], 32'hA0A0_0002);
        end
        chk("st3_done", done_pulses, 1);
        chk("st3_idle", O_Cmd_Ready, 1'b1);

        // Load len=4, gapped load data
        do_reset();
        tick(cmd_in(1'b0, 4));
        x = idle_in(); x.grant = 1; x.ready = 1; tick(x);
        for (int i = 0; i < 6; i++) begin
            x = idle_in(); x.ld_v = (i != 1 && i != 4); x.ld_data = 32'hD000_0000 + i; tick(x);
        end
        for (int i = 0; i < 3; i++) tick(idle_in());
        chk("ld4_count", ld_pulses, 4);
        if (ld_log.size() == 4) chk("ld4_last", ld_log[3], 32'hD000_0005);
        chk("ld4_done", done_pulses, 1);
        chk("ld4_err", O_Err, 1'b0);

        // Grant without ready holds REQ
        do_reset();
        tick(cmd_in(1'b1, 2));
        for (int i = 0; i < 5; i++) begin
            x = idle_in(); x.grant = 1; tick(x);
        end
        chk("hold_req", O_Req, 1'b1);
        x = idle_in(); x.grant = 1; x.ready = 1; tick(x);
        tick(idle_in());
        chk("hold_xfer_req", O_Req, 1'b0);
        chk("hold_xfer_busy", O_Busy, 1'b1);

        // Ready drop mid-burst stalls the core
        do_reset();
        tick(cmd_in(1'b1, 3));
        x = idle_in(); x.grant = 1; x.ready = 1; tick(x);
        x = idle_in(); x.ready = 1; x.cst_v = 1; x.cst_data = 32'h11; tick(x);
        x = idle_in(); x.ready = 0; x.cst_v = 1; x.cst_data = 32'h22; tick(x);
        chk("drop_stall", O_Core_St_Stall, 1'b1);
        x = idle_in(); x.ready = 1; x.cst_v = 1; x.cst_data = 32'h33; tick(x);
        chk("drop_no_stv", O_St_V, 1'b0);
        x.cst_data = 32'h44; tick(x);
        for (int i = 0; i < 3; i++) tick(idle_in());
        chk("drop_count", st_pulses, 3);
        chk("drop_done", done_pulses, 1);

        // Zero length, stray load data, error clears on accept
        do_reset();
        tick(cmd_in(1'b0, 0));
        tick(idle_in());
        chk("zl_done", O_Done, 1'b1);
        x = idle_in(); x.ld_v = 1; tick(x);
        for (int i = 0; i < 3; i++) tick(idle_in());
        chk("zl_err_hold", O_Err, 1'b1);
        chk("zl_no_req", req_pulses, 0);
        tick(cmd_in(1'b0, 0));
        tick(idle_in());
        chk("zl_err_clr", O_Err, 1'b0);

        // Reset during an 8-beat load after 3 beats
        do_reset();
        tick(cmd_in(1'b0, 8));
        x = idle_in(); x.grant = 1; x.ready = 1; tick(x);
        for (int i = 0; i < 3; i++) begin
            x = idle_in(); x.ld_v = 1; x.ld_data = 32'h55 + i; tick(x);
        end
        x = idle_in(); x.rst = 0; tick(x);
        chk("mid_rst_ready", O_Cmd_Ready, 1'b1);
        chk("mid_rst_ldv", O_Core_Ld_V, 1'b0);
        for (int i = 0; i < 4; i++) tick(idle_in());
        chk("mid_rst_nodone", done_pulses, 0);

        // Maximum length store completes with exactly 2^LW-1 beats
        do_reset();
        tick(cmd_in(1'b1, 4095));
        x = idle_in(); x.grant = 1; x.ready = 1; tick(x);
        for (int i = 0; i < 4300 && done_pulses == 0; i++) begin
            x = idle_in(); x.ready = 1; x.cst_v = 1; x.cst_data = DW'(i); tick(x);
        end
        chk("max_done", done_pulses, 1);
        chk("max_beats", st_pulses, 4095);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            x = idle_in();
            x.rst      = ($urandom_range(0, 599) != 0);
            x.valid    = ($urandom_range(0, 3) == 0);
            x.store    = $urandom_range(0, 1);
            x.len      = ($urandom_range(0, 7) == 0) ? LW'(0) : LW'($urandom_range(1, 6));
            x.base     = AW'($urandom);
            x.stride   = AW'($urandom);
            x.grant    = ($urandom_range(0, 2) != 0);
            x.ready    = ($urandom_range(0, 3) != 0);
            x.cst_v    = (ph == 2 && !m_st) ? ($urandom_range(0, 19) == 0) : $urandom_range(0, 1);
            x.cst_data = $urandom;
            x.ld_v     = (ph == 2 && !m_st) ? $urandom_range(0, 1) : ($urandom_range(0, 19) == 0);
            x.ld_data  = $urandom;
            tick(x);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ldst_seq.md
LDST_SEQ -- requirements
Module: ldst_seq

Interface
REQ-001 Parameters SHALL be: ADDR_W, 12, address/stride width; LEN_W, 12, length width; DATA_W, 32, data word width.
REQ-002 clock  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 I_Cmd_Valid  in  1  command valid from TPU core issue stage.
REQ-005 I_Cmd_Store  in  1  1=store, 0=load.
REQ-006 I_Cmd_Base / I_Cmd_Stride  in  ADDR_W each  base address and stride.
REQ-007 I_Cmd_Len  in  LEN_W  element count.
REQ-008 O_Cmd_Ready  out  1  command accepted when high with I_Cmd_Valid.
REQ-009 O_Req, O_V, O_Is_St  out  1 each  descriptor request, descriptor valid, store flag to DMem.
REQ-010 O_Base, O_Stride  out  ADDR_W each; O_Len  out  LEN_W  latched descriptor.
REQ-011 I_Grant, I_Ready  in  1 each  grant and ready from DMem for this port.
REQ-012 I_Core_St_V  in  1; I_Core_St_Data  in  DATA_W  store data from core; O_Core_St_Stall  out  1.
REQ-013 O_St_V  out  1; O_St_Data  out  DATA_W  store data to DMem.
REQ-014 I_Ld_V  in  1; I_Ld_Data  in  DATA_W  load data from DMem.
REQ-015 O_Core_Ld_V  out  1; O_Core_Ld_Data  out  DATA_W  load data to core.
REQ-016 O_Busy, O_Done, O_Err  out  1 each  sequence active, completion pulse, sticky protocol error.

Function
REQ-017 FSM SHALL have states IDLE, REQ, XFER, DONE.
REQ-018 IDLE: O_Cmd_Ready=1; O_Busy=0; all other strobes 0.
REQ-019 IDLE, I_Cmd_Valid=1, I_Cmd_Len!=0: latch base/stride/len/store, clear O_Err, remaining-count := I_Cmd_Len, go REQ.
REQ-020 IDLE, I_Cmd_Valid=1, I_Cmd_Len==0: accept, no request issued, O_Done=1 next cycle, stay IDLE.
REQ-021 REQ: O_Req=1, O_V=1, descriptor outputs driven from latch, O_Cmd_Ready=0, O_Busy=1.
REQ-022 REQ: I_Grant=1 and I_Ready=1 in same cycle -> XFER next cycle; otherwise hold REQ indefinitely.
REQ-023 XFER: O_Req=0, O_V=0, O_Busy=1, O_Cmd_Ready=0; descriptor outputs hold latched values.
REQ-024 XFER store: O_Core_St_Stall = ~I_Ready (combinational); beat = I_Core_St_V & I_Ready.
REQ-025 Store beat SHALL register data: O_St_V=1 and O_St_Data=I_Core_St_Data one cycle after the beat.
REQ-026 XFER load: beat = I_Ld_V; O_Core_Ld_V=1, O_Core_Ld_Data=I_Ld_Data one cycle after beat.
REQ-027 Each beat SHALL decrement remaining-count by 1; beat with count==1 -> DONE next cycle.
REQ-028 Beats of the wrong type in XFER (I_Ld_V during store, I_Core_St_V during load) SHALL be ignored and set O_Err.
REQ-029 I_Ld_V while not in XFER (load) SHALL be dropped and set O_Err; O_Err holds until next command accept.
REQ-030 DONE: O_Done=1 for exactly one cycle, O_Busy=1, then IDLE; O_Cmd_Ready=0 in DONE.
REQ-031 O_Core_St_Stall SHALL be 1 in REQ and DONE, 0 in IDLE.
REQ-032 Max length 2^LEN_W-1 SHALL complete with exactly that many beats; no count wrap.

Reset
REQ-033 reset=0 SHALL asynchronously force IDLE, count=0, latches=0, all outputs 0 except O_Cmd_Ready=1.
REQ-034 reset asserted mid-XFER SHALL abandon the sequence without O_Done; beats registered before reset are discarded.

Verification
REQ-035 Store len=3, grant+ready immediate, 3 consecutive core data A,B,C -> O_St_V on cycles +1..+3 with A,B,C, O_Done 1 cycle after last, back to IDLE.
REQ-036 Load len=4, I_Ld_V gapped (1,0,1,1,0,1) -> 4 O_Core_Ld_V pulses each 1 cycle delayed, O_Done after 4th.
REQ-037 REQ with I_Grant=1, I_Ready=0 for 5 cycles -> stays REQ, O_Req=1; then Ready=1 -> XFER.
REQ-038 Store with I_Ready dropped mid-burst -> O_Core_St_Stall=1, no count change, no O_St_V that cycle.
REQ-039 Cmd len=0 -> O_Done next cycle, O_Req never asserted; stray I_Ld_V in IDLE -> O_Err=1 until next accept.
REQ-040 reset=0 during XFER of len=8 after 3 beats -> immediate IDLE, O_Cmd_Ready=1, no O_Done.
